// File: rtl/snd_pkg.sv
// ---------------------------------------------------------------------------
// snd_pkg : shared defaults and playback state encoding | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package snd_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_RATE_W     = 12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } play_state_e;

endpackage

`default_nettype wire

// File: rtl/snd_fifo.sv
// ---------------------------------------------------------------------------
// snd_fifo : power-of-two sample FIFO with flush, level, full, empty | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module snd_fifo
  import snd_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/covox_player.sv
// ---------------------------------------------------------------------------
// covox_player : rate-timed FIFO sample player sharing the sound port with the CPU | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module covox_player
  import snd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RATE_W     = DEF_RATE_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  cpu_din,
  input  logic                        cpu_beeper_wr,
  input  logic                        cpu_covox_wr,
  input  logic                        fifo_wr,
  input  logic [7:0]                  fifo_din,
  input  logic                        fifo_flush,
  input  logic                        play_en,
  input  logic [RATE_W-1:0]           rate_div,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic                        overflow,
  input  logic                        flags_clr,
  output logic [7:0]                  snd_din,
  output logic                        snd_beeper_wr,
  output logic                        snd_covox_wr
);

  play_state_e       state_q, state_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [7:0]        sample_q, sample_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        snd_din_q, snd_din_d;
  logic              snd_beeper_wr_q, snd_beeper_wr_d;
  logic              snd_covox_wr_q, snd_covox_wr_d;

  logic       tick;
  logic       issue;
  logic       pending_busy;
  logic       pop;
  logic       underrun_set;
  logic       overflow_set;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  snd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_wr),
    .pop   (pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    sample_d        = sample_q;
    snd_din_d       = snd_din_q;
    snd_beeper_wr_d = 1'b0;
    snd_covox_wr_d  = 1'b0;
    tick            = 1'b0;
    issue           = 1'b0;
    pop             = 1'b0;
    underrun_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (play_en) begin
          state_d = ST_RUN;
          cnt_d   = rate_div;
        end
      end
      ST_RUN: begin
        if (!play_en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          tick  = 1'b1;
          cnt_d = rate_div;
        end else begin
          cnt_d = cnt_q - RATE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU writes always win the port; a queued sample waits a cycle.
    if (cpu_beeper_wr) begin
      snd_beeper_wr_d = 1'b1;
      snd_din_d       = cpu_din;
    end else if (cpu_covox_wr) begin
      snd_covox_wr_d = 1'b1;
      snd_din_d      = cpu_din;
    end else if (pending_q) begin
      snd_covox_wr_d = 1'b1;
      snd_din_d      = sample_q;
      issue          = 1'b1;
    end

    // A sample leaving this cycle frees the slot, allowing one write per cycle.
    pending_busy = pending_q && !issue;
    if (issue) pending_d = 1'b0;
    if (tick && !pending_busy) begin
      if (!fifo_empty) begin
        pop       = 1'b1;
        pending_d = 1'b1;
        sample_d  = fifo_dout;
      end else begin
        underrun_set = 1'b1;
      end
    end
    if (state_q == ST_RUN && !play_en) pending_d = 1'b0;

    overflow_set = fifo_wr && fifo_full && !fifo_flush;
    underrun_d   = underrun_set ? 1'b1 : (flags_clr ? 1'b0 : underrun_q);
    overflow_d   = overflow_set ? 1'b1 : (flags_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      sample_q        <= 8'h00;
      underrun_q      <= 1'b0;
      overflow_q      <= 1'b0;
      snd_din_q       <= 8'h00;
      snd_beeper_wr_q <= 1'b0;
      snd_covox_wr_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      sample_q        <= sample_d;
      underrun_q      <= underrun_d;
      overflow_q      <= overflow_d;
      snd_din_q       <= snd_din_d;
      snd_beeper_wr_q <= snd_beeper_wr_d;
      snd_covox_wr_q  <= snd_covox_wr_d;
    end
  end

  assign underrun      = underrun_q;
  assign overflow      = overflow_q;
  assign snd_din       = snd_din_q;
  assign snd_beeper_wr = snd_beeper_wr_q;
  assign snd_covox_wr  = snd_covox_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_covox_player.sv
// ---------------------------------------------------------------------------
// tb_covox_player : directed checks of covox_player playback and arbitration | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_covox_player;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cpu_din;
  logic        cpu_beeper_wr;
  logic        cpu_covox_wr;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        fifo_flush;
  logic        play_en;
  logic [11:0] rate_div;
  logic        fifo_full;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        overflow;
  logic        flags_clr;
  logic [7:0]  snd_din;
  logic        snd_beeper_wr;
  logic        snd_covox_wr;

  int   errors = 0;
  int   checks = 0;
  logic exp_wr;

  covox_player #(
    .FIFO_DEPTH (16),
    .RATE_W     (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_din       (cpu_din),
    .cpu_beeper_wr (cpu_beeper_wr),
    .cpu_covox_wr  (cpu_covox_wr),
    .fifo_wr       (fifo_wr),
    .fifo_din      (fifo_din),
    .fifo_flush    (fifo_flush),
    .play_en       (play_en),
    .rate_div      (rate_div),
    .fifo_full     (fifo_full),
    .fifo_level    (fifo_level),
    .underrun      (underrun),
    .overflow      (overflow),
    .flags_clr     (flags_clr),
    .snd_din       (snd_din),
    .snd_beeper_wr (snd_beeper_wr),
    .snd_covox_wr  (snd_covox_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_wr  = 1'b1;
    fifo_din = v;
    @(negedge clk);
    fifo_wr  = 1'b0;
  endtask

  task automatic clear_flags();
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_din = 8'h00; cpu_beeper_wr = 1'b0; cpu_covox_wr = 1'b0;
    fifo_wr = 1'b0; fifo_din = 8'h00; fifo_flush = 1'b0; play_en = 1'b0;
    rate_div = 12'd0; flags_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_level", fifo_level, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_covox", snd_covox_wr, 0);
    chk("rst_din", snd_din, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_beeper", snd_beeper_wr, 0);

    // Rate: period 4, four samples then underrun on the fifth tick
    rate_div = 12'd3;
    push(8'd10); push(8'd20); push(8'd30); push(8'd40);
    chk("rate_level", fifo_level, 4);
    play_en = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      exp_wr = (c == 6 || c == 10 || c == 14 || c == 18);
      chk("rate_covox", snd_covox_wr, exp_wr);
      if (exp_wr) chk("rate_din", snd_din, 10 * ((c - 2) / 4));
      if (c == 20) chk("rate_no_underrun", underrun, 0);
      if (c == 21) chk("rate_underrun", underrun, 1);
    end
    play_en = 1'b0;
    clear_flags();
    chk("rate_flag_clr", underrun, 0);

    // Collision: CPU write and queued sample in the same cycle
    push(8'h80);
    play_en = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) begin
        cpu_covox_wr = 1'b1;
        cpu_din      = 8'h11;
      end
      if (c == 6) begin
        cpu_covox_wr = 1'b0;
        chk("col_cpu_wr", snd_covox_wr, 1);
        chk("col_cpu_din", snd_din, 8'h11);
      end
      if (c == 7) begin
        play_en = 1'b0;
        chk("col_smp_wr", snd_covox_wr, 1);
        chk("col_smp_din", snd_din, 8'h80);
      end
      if (c == 8) chk("col_quiet", snd_covox_wr, 0);
    end
    chk("col_no_underrun", underrun, 0);

    // Overflow: 17 pushes while idle
    for (int k = 1; k <= 16; k++) push(8'(32'h40 + k));
    chk("ovf_full", fifo_full, 1);
    chk("ovf_level16", fifo_level, 16);
    chk("ovf_not_yet", overflow, 0);
    push(8'hEE);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level_kept", fifo_level, 16);
    clear_flags();
    chk("ovf_clr", overflow, 0);

    // rate_div=0 drains the full FIFO at one write per cycle
    rate_div = 12'd0;
    play_en  = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      exp_wr = (c >= 3 && c <= 18);
      chk("fast_covox", snd_covox_wr, exp_wr);
      if (exp_wr) chk("fast_din", snd_din, 32'h40 + (c - 2));
      if (c == 2) chk("fast_level", fifo_level, 15);
      if (c == 17) chk("fast_no_underrun", underrun, 0);
      if (c == 18) chk("fast_underrun", underrun, 1);
    end
    play_en = 1'b0;
    clear_flags();

    // Mid-play disable keeps queued samples, re-enable resumes in order
    rate_div = 12'd3;
    for (int k = 1; k <= 5; k++) push(8'(k));
    play_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("dis_second_wr", snd_covox_wr, 1);
    chk("dis_second_din", snd_din, 2);
    chk("dis_level_before", fifo_level, 3);
    play_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("dis_quiet", snd_covox_wr, 0);
    end
    chk("dis_level_kept", fifo_level, 3);
    play_en = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      exp_wr = (c == 6 || c == 10 || c == 14);
      chk("res_covox", snd_covox_wr, exp_wr);
      if (exp_wr) chk("res_din", snd_din, 2 + (c - 2) / 4);
    end
    play_en = 1'b0;
    chk("res_level", fifo_level, 0);

    // Simultaneous CPU strobes forward beeper only; din holds afterwards
    cpu_beeper_wr = 1'b1; cpu_covox_wr = 1'b1; cpu_din = 8'h55;
    @(negedge clk);
    cpu_beeper_wr = 1'b0; cpu_covox_wr = 1'b0;
    chk("both_beeper", snd_beeper_wr, 1);
    chk("both_covox", snd_covox_wr, 0);
    chk("both_din", snd_din, 8'h55);
    @(negedge clk);
    chk("hold_beeper", snd_beeper_wr, 0);
    chk("hold_din", snd_din, 8'h55);

    // Flush empties the FIFO and drops a same-cycle push
    push(8'h01); push(8'h02);
    chk("flush_pre", fifo_level, 2);
    fifo_flush = 1'b1; fifo_wr = 1'b1; fifo_din = 8'h03;
    @(negedge clk);
    fifo_flush = 1'b0; fifo_wr = 1'b0;
    chk("flush_level", fifo_level, 0);
    chk("flush_no_ovf", overflow, 0);

    // Asynchronous reset mid-RUN with a sample pending
    push(8'h77); push(8'h78);
    play_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_pre_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_full", fifo_full, 0);
    chk("arst_din", snd_din, 8'h00);
    chk("arst_covox", snd_covox_wr, 0);
    chk("arst_beeper", snd_beeper_wr, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_overflow", overflow, 0);
    play_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("arst_rel_covox", snd_covox_wr, 0);
      chk("arst_rel_beeper", snd_beeper_wr, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/covox_player.md
COVOX_PLAYER -- requirements
Module: covox_player

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries (power of two).
REQ-002 SHALL have parameter RATE_W, default 12, width of sample-rate divider.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports cpu_din input 8, cpu_beeper_wr input 1, cpu_covox_wr input 1: CPU port data and one-cycle write strobes.
REQ-006 SHALL have ports fifo_wr input 1, fifo_din input 8, fifo_flush input 1: sample push, sample data, FIFO clear.
REQ-007 SHALL have ports play_en input 1, rate_div input RATE_W: playback enable, tick period minus one.
REQ-008 SHALL have ports fifo_full output 1, fifo_level output log2(FIFO_DEPTH)+1: FIFO status.
REQ-009 SHALL have ports underrun output 1, overflow output 1, flags_clr input 1: sticky error flags and their clear.
REQ-010 SHALL have ports snd_din output 8, snd_beeper_wr output 1, snd_covox_wr output 1: drive the sound block's din/beeper_wr/covox_wr.

Function
REQ-011 SHALL run a tick counter in state RUN: loads rate_div, decrements each clk, asserts tick for one cycle at zero and reloads; tick period = rate_div+1 cycles (rate_div=0 -> every cycle).
REQ-012 SHALL have states IDLE (play_en=0) and RUN (play_en=1); IDLE->RUN loads counter with rate_div, first tick rate_div+1 cycles later; RUN->IDLE clears counter and pending flag, FIFO contents kept.
REQ-013 SHALL on tick with FIFO non-empty pop one sample into a pending register and set pending.
REQ-014 SHALL on tick with FIFO empty and pending clear set underrun, issue nothing (sound block holds last level).
REQ-015 SHALL ignore a tick while pending is set (no pop, no flag).
REQ-016 SHALL arbitrate the sound port with CPU priority: a cycle with cpu_beeper_wr or cpu_covox_wr forwards the CPU write; otherwise a pending sample issues as snd_covox_wr with snd_din=sample, clearing pending.
REQ-017 SHALL register all snd_* outputs: CPU strobe at cycle N appears at N+1; pending sample issues earliest one cycle after pop.
REQ-018 SHALL keep snd_beeper_wr and snd_covox_wr mutually exclusive; simultaneous CPU beeper+covox strobes forward beeper only.
REQ-019 SHALL push fifo_din on fifo_wr when not full; fifo_wr when full drops the data and sets overflow.
REQ-020 SHALL on simultaneous push and pop perform both, level unchanged; push into empty FIFO is not poppable the same cycle.
REQ-021 SHALL on fifo_flush empty the FIFO and ignore a same-cycle fifo_wr; pending sample is kept.
REQ-022 SHALL clear underrun/overflow on flags_clr; a same-cycle set event wins.
REQ-023 SHALL keep snd_din stable between write strobes.

Reset
REQ-024 SHALL on rst_n low asynchronously force: state IDLE, counter 0, pending 0, FIFO empty (fifo_level 0, fifo_full 0), underrun 0, overflow 0, snd_din 8'h00, snd_beeper_wr 0, snd_covox_wr 0.
REQ-025 SHALL release reset with no write strobe in the first cycle after deassertion.

Structure
REQ-026 SHALL place FIFO_DEPTH/RATE_W defaults and the IDLE/RUN state encoding in shared package snd_pkg.
REQ-027 SHALL implement the FIFO as sub-module snd_fifo (push/pop/flush, level, full, empty).

Verification
REQ-028 SHALL test rate: rate_div=3, push 4 samples 10,20,30,40, play_en=1 -> snd_covox_wr pulses every 4 cycles with snd_din 10,20,30,40, then underrun=1 on 5th tick.
REQ-029 SHALL test collision: pending sample 8'h80 and cpu_covox_wr with 8'h11 same cycle -> 8'h11 forwarded first, 8'h80 one cycle later.
REQ-030 SHALL test overflow: 17 pushes with play_en=0 -> fifo_full=1, level 16, overflow=1, 17th value never output.
REQ-031 SHALL test mid-play disable: play_en low with 3 samples queued -> no further covox writes, level 3 retained; re-enable resumes in order.
REQ-032 SHALL test reset: rst_n low mid-RUN, pending set -> all outputs to reset values immediately, no write after release.
REQ-033 SHALL test rate_div=0 with full FIFO -> one covox write per cycle, 16 writes, then underrun.
